// File: rtl/stream_block_checksum_pkg.sv
// stream_block_checksum_pkg: shared FSM states, CSR addresses and CSR bit positions.
package stream_block_checksum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_SUM    = 2'd2;
    localparam logic [1:0] ADDR_INFO   = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;
    localparam int CTRL_CLEAR = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_OVF  = 2;

endpackage

// File: rtl/stream_block_checksum_csr.sv
// stream_block_checksum_csr: CTRL write decode and registered CSR readback.
module stream_block_checksum_csr
    import stream_block_checksum_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              read,
    input  logic              write,
    input  logic [2:0]        writedata,
    input  logic [LEN_W-1:0]  len,
    input  logic [LEN_W-1:0]  count,
    input  logic [DATA_W-1:0] sum,
    input  logic              overflow,
    input  logic              done,
    input  logic              busy,
    input  logic [7:0]        errcnt,
    input  logic [7:0]        last_channel,
    output logic              start,
    output logic              abort,
    output logic              clear,
    output logic [DATA_W-1:0] readdata
);

    logic ctrl_wr;
    logic [2:0] status_bits;

    // Only the CTRL word has writable effect; other addresses ignore writes
    always_comb begin
        ctrl_wr                = write && address == ADDR_CTRL;
        start                  = ctrl_wr && writedata[CTRL_START];
        abort                  = ctrl_wr && writedata[CTRL_ABORT];
        clear                  = ctrl_wr && writedata[CTRL_CLEAR];
        status_bits            = '0;
        status_bits[STAT_BUSY] = busy;
        status_bits[STAT_DONE] = done;
        status_bits[STAT_OVF]  = overflow;
    end

    // Read data is captured on the strobe cycle and presented the cycle after
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            readdata <= '0;
        else if (read)
            readdata <= (address == ADDR_CTRL)   ? {len, {(DATA_W-LEN_W){1'b0}}} :
                        (address == ADDR_STATUS) ? {count, {(DATA_W-LEN_W-3){1'b0}}, status_bits} :
                        (address == ADDR_SUM)    ? sum :
                                                   {{(DATA_W-16){1'b0}}, last_channel, errcnt};
    end

endmodule

// File: rtl/stream_block_checksum.sv
// stream_block_checksum: accepts a CSR-programmed number of stream beats and sums them modulo 2^DATA_W.
// Optional feature: define STREAM_BLOCK_CHECKSUM_ERRCNT_EN to count errored beats and capture the last channel.
module stream_block_checksum
    import stream_block_checksum_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] avalonst_sink_data,
    input  logic [7:0]        avalonst_sink_channel,
    input  logic [7:0]        avalonst_sink_error,
    input  logic              avalonst_sink_valid,
    output logic              avalonst_sink_ready,
    input  logic [1:0]        avalonmm_slave_address,
    input  logic              avalonmm_slave_read,
    input  logic              avalonmm_slave_write,
    input  logic [DATA_W-1:0] avalonmm_slave_writedata,
    output logic [DATA_W-1:0] avalonmm_slave_readdata,
    output logic              irq
);

    state_t state, state_next;
    logic [LEN_W-1:0]  len, count;
    logic [LEN_W:0]    count_inc, count_fill;
    logic [DATA_W-1:0] sum;
    logic [7:0]        errcnt, last_channel;
    logic ready_q, overflow, busy, done, start, abort, clear, start_ok, take;
    logic unused_bits;

    // count_fill counts a possibly in-flight beat so ready never over-grants the block
    assign count_inc  = {1'b0, count} + (LEN_W+1)'(1);
    assign count_fill = {1'b0, count} + (LEN_W+1)'(ready_q);
    assign start_ok   = start && !abort && state == IDLE;
    assign take       = avalonst_sink_valid && ready_q && state == RUN && !abort;

    stream_block_checksum_csr #(.DATA_W(DATA_W), .LEN_W(LEN_W)) u_csr (
        .clock        (clock),
        .reset_n      (reset_n),
        .address      (avalonmm_slave_address),
        .read         (avalonmm_slave_read),
        .write        (avalonmm_slave_write),
        .writedata    (avalonmm_slave_writedata[2:0]),
        .len          (len),
        .count        (count),
        .sum          (sum),
        .overflow     (overflow),
        .done         (done),
        .busy         (busy),
        .errcnt       (errcnt),
        .last_channel (last_channel),
        .start        (start),
        .abort        (abort),
        .clear        (clear),
        .readdata     (avalonmm_slave_readdata)
    );

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next state: abort wins from anywhere; RUN finishes on the last beat or immediately for len 0
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN:     state_next = (count == len || (take && count_inc == {1'b0, len})) ? DONE : RUN;
            DONE:    state_next = clear ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
        if (abort)
            state_next = IDLE;
    end

    // Outputs: ready is built from registered terms only
    always_comb begin
        busy                = state == RUN;
        done                = state == DONE;
        avalonst_sink_ready = busy && count_fill < {1'b0, len};
    end

    // Block datapath: length latch, beat count, running sum, sticky overflow and level irq
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_q  <= 1'b0;
            irq      <= 1'b0;
            len      <= '0;
            count    <= '0;
            sum      <= '0;
            overflow <= 1'b0;
        end else begin
            ready_q <= avalonst_sink_ready;
            irq     <= state_next == DONE;
            if (start_ok) begin
                len      <= avalonmm_slave_writedata[DATA_W-1 -: LEN_W];
                count    <= '0;
                sum      <= '0;
                overflow <= 1'b0;
            end else begin
                if (take) begin
                    count <= count_inc[LEN_W-1:0];
                    sum   <= sum + avalonst_sink_data;
                end
                if (avalonst_sink_valid && !ready_q)
                    overflow <= 1'b1;
            end
        end
    end

`ifdef STREAM_BLOCK_CHECKSUM_ERRCNT_EN
    // Saturating count of errored beats and channel of the most recent accepted beat
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            errcnt       <= '0;
            last_channel <= '0;
        end else if (start_ok) begin
            errcnt <= '0;
        end else if (take) begin
            errcnt       <= (avalonst_sink_error != 8'd0 && errcnt != 8'hFF) ? errcnt + 8'd1 : errcnt;
            last_channel <= avalonst_sink_channel;
        end
    end
    assign unused_bits = ^avalonmm_slave_writedata[DATA_W-LEN_W-1:3];
`else
    assign errcnt       = '0;
    assign last_channel = '0;
    assign unused_bits  = ^{avalonst_sink_channel, avalonst_sink_error, avalonmm_slave_writedata[DATA_W-LEN_W-1:3]};
`endif

endmodule

// File: tb/tb_stream_block_checksum.sv
// tb_stream_block_checksum: random block traffic against a sum/length model, CSR reads checked by a scoreboard.
module tb_stream_block_checksum;
    import stream_block_checksum_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  ch;
        logic [7:0]  err;
        bit          raw;
    } beat_t;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] sdata;
    logic [7:0]  schan, serr;
    logic        svalid, sready;
    logic [1:0]  addr = 2'd0;
    logic        rd = 1'b0, wr = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        irq;

    beat_t src_q[$];
    exp_t  sb[$];
    int    checks = 0, errors = 0;
    bit    gaps = 0;

    logic [15:0] m_len;
    logic [31:0] m_sum;
    logic [7:0]  m_ch = 8'd0;
    bit          m_ovf;
    int          m_err;

    stream_block_checksum dut (
        .clock                    (clock),
        .reset_n                  (reset_n),
        .avalonst_sink_data       (sdata),
        .avalonst_sink_channel    (schan),
        .avalonst_sink_error      (serr),
        .avalonst_sink_valid      (svalid),
        .avalonst_sink_ready      (sready),
        .avalonmm_slave_address   (addr),
        .avalonmm_slave_read      (rd),
        .avalonmm_slave_write     (wr),
        .avalonmm_slave_writedata (wdata),
        .avalonmm_slave_readdata  (rdata),
        .irq                      (irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] status(input logic [15:0] cnt, input bit ovf, input bit dn, input bit bsy);
        return {cnt, 13'b0, ovf, dn, bsy};
    endfunction

    function automatic logic [31:0] info();
`ifdef STREAM_BLOCK_CHECKSUM_ERRCNT_EN
        return {16'h0, m_ch, (m_err > 255) ? 8'd255 : 8'(m_err)};
`else
        return 32'h0;
`endif
    endfunction

    // Stream source with readyLatency 1: a compliant beat goes out only if ready was high last cycle
    initial begin : source
        bit    r_prev;
        beat_t b;
        r_prev = 0;
        svalid = 0;
        sdata  = '0;
        schan  = '0;
        serr   = '0;
        forever begin
            @(posedge clock);
            #2;
            svalid = 0;
            if (src_q.size() > 0 && (src_q[0].raw || (r_prev && !(gaps && $urandom_range(0, 2) == 0)))) begin
                b      = src_q.pop_front();
                sdata  = b.data;
                schan  = b.ch;
                serr   = b.err;
                svalid = 1;
            end
            r_prev = sready;
        end
    end

    // Scoreboard monitor: readdata is due one cycle after each read strobe
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            if (rd) begin
                #1;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got 0x%08h with no expectation queued", rdata);
                end else begin
                    e = sb.pop_front();
                    check(e.name, rdata, e.exp);
                end
            end
        end
    end

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clock);
        addr  = a;
        wdata = d;
        wr    = 1;
        @(negedge clock);
        wr = 0;
    endtask

    task automatic csr_read(input logic [1:0] a, input logic [31:0] exp, input string name);
        exp_t e;
        @(negedge clock);
        addr   = a;
        rd     = 1;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
        @(negedge clock);
        rd = 0;
    endtask

    task automatic start_block(input logic [15:0] len);
        m_len = len;
        m_sum = 0;
        m_err = 0;
        m_ovf = 0;
        csr_write(ADDR_CTRL, {len, 16'h0001});
    endtask

    task automatic push_beat(input logic [31:0] d, input logic [7:0] c, input logic [7:0] e);
        beat_t b;
        b.data = d;
        b.ch   = c;
        b.err  = e;
        b.raw  = 0;
        src_q.push_back(b);
        m_sum += d;
        if (e != 0) m_err++;
        m_ch = c;
    endtask

    task automatic drain();
        int n = 0;
        while (src_q.size() > 0 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check("source_drained", 32'(src_q.size()), 0);
    endtask

    task automatic finish_block(input bit do_clear);
        int n = 0;
        while (!irq && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check("irq_done", 32'(irq), 1);
        check("ready_done", 32'(sready), 0);
        csr_read(ADDR_STATUS, status(m_len, m_ovf, 1, 0), "status_done");
        csr_read(ADDR_SUM, m_sum, "sum_done");
        csr_read(ADDR_CTRL, {m_len, 16'h0}, "len_done");
        csr_read(ADDR_INFO, info(), "info_done");
        if (do_clear) begin
            csr_write(ADDR_CTRL, 32'h4);
            check("irq_cleared", 32'(irq), 0);
            csr_read(ADDR_STATUS, status(m_len, m_ovf, 0, 0), "status_idle");
        end
    endtask

    task automatic random_beats(input int n);
        for (int i = 0; i < n; i++)
            push_beat($urandom, 8'($urandom), ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 255)) : 8'h00);
    endtask

    initial begin : main
        beat_t raw;
        int    n;
        raw.raw = 1;
        m_len = 0; m_sum = 0; m_ovf = 0; m_err = 0;

        // Reset state
        repeat (3) @(negedge clock);
        check("reset_irq", 32'(irq), 0);
        check("reset_ready", 32'(sready), 0);
        reset_n = 1;
        csr_read(ADDR_CTRL, 32'h0, "reset_ctrl");
        csr_read(ADDR_STATUS, 32'h0, "reset_status");
        csr_read(ADDR_SUM, 32'h0, "reset_sum");
        csr_read(ADDR_INFO, 32'h0, "reset_info");

        // len 4, beats 1..4 back to back; then start and other-address writes must be ignored in DONE
        gaps = 0;
        start_block(16'd4);
        for (int i = 1; i <= 4; i++) push_beat(32'(i), 8'(i), 8'h00);
        finish_block(0);
        csr_write(ADDR_CTRL, 32'h0055_0001);
        csr_write(ADDR_STATUS, 32'hFFFF_FFFF);
        csr_write(ADDR_SUM, 32'hDEAD_BEEF);
        csr_write(ADDR_INFO, 32'hFFFF_FFFF);
        check("irq_held_done", 32'(irq), 1);
        csr_read(ADDR_CTRL, 32'h0004_0000, "len_kept");
        csr_read(ADDR_SUM, 32'd10, "sum_is_10");
        csr_read(ADDR_STATUS, status(16'd4, 0, 1, 0), "status_kept");
        csr_write(ADDR_CTRL, 32'h4);
        check("irq_clear_4", 32'(irq), 0);

        // len 3 with source gaps
        gaps = 1;
        start_block(16'd3);
        random_beats(3);
        finish_block(1);

        // len 0: DONE and irq one edge after start, ready never high
        gaps = 0;
        start_block(16'd0);
        check("len0_ready_run", 32'(sready), 0);
        check("len0_irq_run", 32'(irq), 0);
        @(negedge clock);
        check("len0_irq", 32'(irq), 1);
        finish_block(1);

        // Abort with an in-flight beat, then an unsolicited beat in IDLE
        start_block(16'd8);
        for (int i = 0; i < 3; i++) push_beat($urandom, 8'h11, 8'h00);
        drain();
        repeat (3) @(negedge clock);
        check("abort_pre_ready", 32'(sready), 1);
        @(negedge clock);
        addr  = ADDR_CTRL;
        wdata = 32'h2;
        wr    = 1;
        raw.data = 32'hFFFF_FFFF; raw.ch = 8'h22; raw.err = 8'h01;
        src_q.push_back(raw);
        @(negedge clock);
        wr = 0;
        check("abort_irq", 32'(irq), 0);
        repeat (2) @(negedge clock);
        csr_read(ADDR_STATUS, status(16'd3, 0, 0, 0), "abort_status");
        csr_read(ADDR_SUM, m_sum, "abort_sum_held");
        csr_read(ADDR_INFO, info(), "abort_info");
        src_q.push_back(raw);
        repeat (3) @(negedge clock);
        csr_read(ADDR_STATUS, status(16'd3, 1, 0, 0), "idle_overflow");
        csr_read(ADDR_SUM, m_sum, "idle_sum_held");

        // Sum wraps modulo 2^32
        start_block(16'd2);
        push_beat(32'hFFFF_FFFF, 8'h05, 8'h00);
        push_beat(32'h0000_0002, 8'h06, 8'h00);
        finish_block(1);
        csr_read(ADDR_SUM, 32'h0000_0001, "sum_wrap");

        // 300 errored beats saturate the error counter
        gaps = 0;
        start_block(16'd300);
        for (int i = 0; i < 300; i++) push_beat($urandom, 8'($urandom), 8'h01);
        finish_block(1);

        // Reset mid-RUN discards the block
        start_block(16'd10);
        random_beats(4);
        drain();
        repeat (2) @(negedge clock);
        reset_n = 0;
        @(negedge clock);
        check("rst_irq", 32'(irq), 0);
        check("rst_ready", 32'(sready), 0);
        reset_n = 1;
        @(negedge clock);
        check("rst_ready_after", 32'(sready), 0);
        m_len = 0; m_sum = 0; m_ch = 0; m_err = 0; m_ovf = 0;
        csr_read(ADDR_CTRL, 32'h0, "rst_ctrl");
        csr_read(ADDR_STATUS, 32'h0, "rst_status");
        csr_read(ADDR_SUM, 32'h0, "rst_sum");
        csr_read(ADDR_INFO, 32'h0, "rst_info");

        // Random blocks after reset
        for (int k = 0; k < 5; k++) begin
            gaps = ($urandom_range(0, 1) != 0);
            n = $urandom_range(1, 12);
            start_block(16'(n));
            random_beats(n);
            finish_block(1);
        end

        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("scoreboard_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
